// File: rtl/bsg_counter_dynamic_limit_en.sv
// Counter with a run-time inclusive limit, clock enable, synchronous clear, wrap or
// saturate mode, and wrap-event pulse and count outputs.
module bsg_counter_dynamic_limit_en #(
  parameter int unsigned width_p      = 32,
  parameter int unsigned wrap_width_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    sat_i,
  input  logic [width_p-1:0]      limit_i,
  output logic [width_p-1:0]      counter_o,
  output logic                    at_limit_o,
  output logic                    wrap_o,
  output logic [wrap_width_p-1:0] wrap_count_o
);

  logic [width_p-1:0]      counter_q, counter_d;
  logic                    wrap_q, wrap_d;
  logic [wrap_width_p-1:0] wrap_cnt_q, wrap_cnt_d;
  logic                    below_limit;

  // The >= branch also covers a limit lowered beneath the current count, so the
  // increment below can never overflow width_p.
  assign below_limit = (counter_q < limit_i);

  always_comb begin
    counter_d  = counter_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_d     = 1'b0;
    if (clear_i) begin
      counter_d  = '0;
      wrap_cnt_d = '0;
    end else if (en_i) begin
      if (below_limit) begin
        counter_d = counter_q + width_p'(1);
      end else if (sat_i) begin
        counter_d = limit_i;
      end else begin
        counter_d  = '0;
        wrap_d     = 1'b1;
        wrap_cnt_d = wrap_cnt_q + wrap_width_p'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      counter_q  <= '0;
      wrap_q     <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      counter_q  <= counter_d;
      wrap_q     <= wrap_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign counter_o    = counter_q;
  assign wrap_o       = wrap_q;
  assign wrap_count_o = wrap_cnt_q;
  assign at_limit_o   = (counter_q == limit_i);

endmodule

// File: tb/tb_bsg_counter_dynamic_limit_en.sv
// Self-checking bench: an 8-bit/2-bit-wrap-count instance and a 4-bit/3-bit instance
// share control inputs and are compared every cycle against an arithmetic model.
module tb_bsg_counter_dynamic_limit_en;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0, clear = 1'b0, sat = 1'b0;
  logic [7:0] limit8 = '0;
  logic [3:0] limit4 = '0;
  logic [7:0] cnt8;
  logic       at8, wrap8;
  logic [1:0] wc8;
  logic [3:0] cnt4;
  logic       at4, wrap4;
  logic [2:0] wc4;

  int total = 0;
  int bad = 0;

  // Model state
  int unsigned m8_cnt = 0, m8_wc = 0, m4_cnt = 0, m4_wc = 0;
  bit          m8_wrap = 0, m4_wrap = 0;

  bsg_counter_dynamic_limit_en #(.width_p(8), .wrap_width_p(2)) dut8 (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .clear_i(clear), .sat_i(sat),
    .limit_i(limit8), .counter_o(cnt8), .at_limit_o(at8), .wrap_o(wrap8),
    .wrap_count_o(wc8)
  );

  bsg_counter_dynamic_limit_en #(.width_p(4), .wrap_width_p(3)) dut4 (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .clear_i(clear), .sat_i(sat),
    .limit_i(limit4), .counter_o(cnt4), .at_limit_o(at4), .wrap_o(wrap4),
    .wrap_count_o(wc4)
  );

  always #5 clk = ~clk;

  function automatic void model_step(input int unsigned cnt, input int unsigned wc,
                                     input int unsigned lim, input int unsigned wcw,
                                     input bit e, input bit c, input bit s,
                                     output int unsigned ncnt, output int unsigned nwc,
                                     output bit nwrap);
    ncnt  = cnt;
    nwc   = wc;
    nwrap = 0;
    if (c) begin
      ncnt = 0;
      nwc  = 0;
    end else if (e) begin
      if (cnt < lim) ncnt = cnt + 1;
      else if (s) ncnt = lim;
      else begin
        ncnt  = 0;
        nwrap = 1;
        nwc   = (wc + 1) % (1 << wcw);
      end
    end
  endfunction

  // One clock edge; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    int unsigned a, b, c2, d;
    bit w8, w4;
    model_step(m8_cnt, m8_wc, limit8, 2, en, clear, sat, a, b, w8);
    model_step(m4_cnt, m4_wc, limit4, 3, en, clear, sat, c2, d, w4);
    @(posedge clk);
    #1;
    m8_cnt = a; m8_wc = b; m8_wrap = w8;
    m4_cnt = c2; m4_wc = d; m4_wrap = w4;
  endtask

  task automatic test_reset();
    en = 1'b1;
    limit8 = 8'd3;
    limit4 = 4'd3;
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (cnt8 !== 8'd0 || wrap8 !== 1'b0 || wc8 !== 2'd0 || cnt4 !== 4'd0) begin
      bad++;
      $display("FAIL reset_hold: cnt8=%0d wrap8=%0d wc8=%0d cnt4=%0d, want all 0",
               cnt8, wrap8, wc8, cnt4);
    end
    en = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic_wrap();
    int wraps = 0;
    limit8 = 8'd3;
    sat = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (cnt8 !== 8'(m8_cnt) || wrap8 !== m8_wrap || wc8 !== 2'(m8_wc) ||
          at8 !== (m8_cnt == 3)) begin
        bad++;
        $display("FAIL basic_wrap[%0d]: cnt=%0d wrap=%0d wc=%0d at=%0d, want %0d %0d %0d %0d",
                 i, cnt8, wrap8, wc8, at8, m8_cnt, m8_wrap, m8_wc, m8_cnt == 3);
      end
      if (wrap8 === 1'b1) wraps++;
    end
    total++;
    if (cnt8 !== 8'd2 || wc8 !== 2'd2 || wraps != 2) begin
      bad++;
      $display("FAIL basic_wrap_end: cnt=%0d wc=%0d pulses=%0d, want 2 2 2", cnt8, wc8, wraps);
    end
    en = 1'b0;
  endtask

  task automatic test_sat_enable();
    bit ens [8] = '{1, 0, 1, 1, 1, 1, 1, 1};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    limit8 = 8'd5;
    sat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      en = ens[i];
      tick();
      total++;
      if (cnt8 !== 8'(m8_cnt) || wrap8 !== 1'b0 || at8 !== (m8_cnt == 5)) begin
        bad++;
        $display("FAIL sat_enable[%0d]: cnt=%0d wrap=%0d at=%0d, want %0d 0 %0d",
                 i, cnt8, wrap8, at8, m8_cnt, m8_cnt == 5);
      end
    end
    total++;
    if (cnt8 !== 8'd5 || at8 !== 1'b1) begin
      bad++;
      $display("FAIL sat_stick: cnt=%0d at=%0d, want 5 1", cnt8, at8);
    end
    en = 1'b0;
  endtask

  task automatic test_lowered_limit();
    for (int mode = 0; mode < 2; mode++) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      limit8 = 8'd50;
      sat = 1'b0;
      en = 1'b1;
      repeat (20) tick();
      total++;
      if (cnt8 !== 8'd20) begin
        bad++;
        $display("FAIL lower_pre[%0d]: cnt=%0d, want 20", mode, cnt8);
      end
      sat = mode[0];
      limit8 = 8'd10;
      tick();
      total++;
      if (mode == 0 && (cnt8 !== 8'd0 || wrap8 !== 1'b1)) begin
        bad++;
        $display("FAIL lower_wrap: cnt=%0d wrap=%0d, want 0 1", cnt8, wrap8);
      end else if (mode == 1 && (cnt8 !== 8'd10 || wrap8 !== 1'b0)) begin
        bad++;
        $display("FAIL lower_clamp: cnt=%0d wrap=%0d, want 10 0", cnt8, wrap8);
      end
    end
    en = 1'b0;
    sat = 1'b0;
  endtask

  task automatic test_clear_reset();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    limit8 = 8'd7;
    sat = 1'b0;
    en = 1'b1;
    repeat (31) tick();
    total++;
    if (cnt8 !== 8'd7 || wc8 !== 2'd3) begin
      bad++;
      $display("FAIL clear_pre: cnt=%0d wc=%0d, want 7 3", cnt8, wc8);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total++;
    if (cnt8 !== 8'd0 || wc8 !== 2'd0 || wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL clear: cnt=%0d wc=%0d wrap=%0d, want 0 0 0", cnt8, wc8, wrap8);
    end
    repeat (9) tick();
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (cnt8 !== 8'd0 || wc8 !== 2'd0 || wrap8 !== 1'b0 || cnt4 !== 4'd0 || wc4 !== 3'd0) begin
      bad++;
      $display("FAIL async_reset: cnt8=%0d wc8=%0d wrap8=%0d cnt4=%0d wc4=%0d, want 0",
               cnt8, wc8, wrap8, cnt4, wc4);
    end
    m8_cnt = 0; m8_wc = 0; m8_wrap = 0;
    m4_cnt = 0; m4_wc = 0; m4_wrap = 0;
    en = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_rollover_limit0();
    int unsigned want_wc [6] = '{1, 2, 3, 0, 1, 2};
    limit8 = 8'd0;
    sat = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (cnt8 !== 8'd0 || wrap8 !== 1'b1 || wc8 !== 2'(want_wc[i]) || at8 !== 1'b1) begin
        bad++;
        $display("FAIL limit0[%0d]: cnt=%0d wrap=%0d wc=%0d at=%0d, want 0 1 %0d 1",
                 i, cnt8, wrap8, wc8, at8, want_wc[i]);
      end
    end
    sat = 1'b1;
    tick();
    total++;
    if (cnt8 !== 8'd0 || wrap8 !== 1'b0 || wc8 !== 2'd2) begin
      bad++;
      $display("FAIL limit0_sat: cnt=%0d wrap=%0d wc=%0d, want 0 0 2", cnt8, wrap8, wc8);
    end
    en = 1'b0;
    sat = 1'b0;
  endtask

  task automatic test_full_range();
    int pulses = 0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    limit4 = 4'd15;
    sat = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      tick();
      total++;
      if (cnt4 !== 4'(i % 16) || wrap4 !== (i % 16 == 0) || cnt4 !== 4'(m4_cnt)) begin
        bad++;
        $display("FAIL full_range[%0d]: cnt=%0d wrap=%0d, want %0d %0d",
                 i, cnt4, wrap4, i % 16, i % 16 == 0);
      end
      if (wrap4 === 1'b1) pulses++;
    end
    total++;
    if (pulses != 2 || wc4 !== 3'd2) begin
      bad++;
      $display("FAIL full_range_wraps: pulses=%0d wc=%0d, want 2 2", pulses, wc4);
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 7) == 0) sat = ~sat;
      if ($urandom_range(0, 9) == 0)
        limit8 = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) limit4 = 4'($urandom);
      tick();
      total++;
      if (cnt8 !== 8'(m8_cnt) || wrap8 !== m8_wrap || wc8 !== 2'(m8_wc) ||
          at8 !== (m8_cnt == limit8) || cnt4 !== 4'(m4_cnt) || wrap4 !== m4_wrap ||
          wc4 !== 3'(m4_wc) || at4 !== (m4_cnt == limit4)) begin
        bad++;
        $display("FAIL random[%0d]: d8=%0d/%0d/%0d/%0d m8=%0d/%0d/%0d d4=%0d/%0d/%0d m4=%0d/%0d/%0d",
                 i, cnt8, wrap8, wc8, at8, m8_cnt, m8_wrap, m8_wc,
                 cnt4, wrap4, wc4, m4_cnt, m4_wrap, m4_wc);
      end
    end
    en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_wrap();
    test_sat_enable();
    test_lowered_limit();
    test_clear_reset();
    test_rollover_limit0();
    test_full_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bsg_counter_dynamic_limit_en.md
# bsg_counter_dynamic_limit_en

Parametrised free-running counter with a run-time limit, clock enable, synchronous clear, a selectable wrap or saturate mode, and wrap-event reporting. It generalises the fixed 32-bit dynamic-limit counter:
- width is a parameter;
- a limit lowered below the current count is handled safely;
- wrap events are exported as a pulse and a running count.

It serves as a timebase, credit or round-robin index generator in control paths.

## Interface
Parameters:
- width_p, 32, counter and limit width in bits (>= 1)
- wrap_width_p, 8, width of the wrap-event counter (>= 1)

Ports:
- clk_i  input  1  clock; all state updates on the rising edge
- reset_n_i  input  1  reset, asynchronous and active-low
- en_i  input  1  advance the counter this cycle
- clear_i  input  1  synchronous clear of counter, wrap count and wrap pulse
- sat_i  input  1  mode: 0 = wrap to 0 after the limit, 1 = saturate at the limit
- limit_i  input  width_p  inclusive terminal count, unsigned, may change any cycle
- counter_o  output  width_p  current count (registered)
- at_limit_o  output  1  combinational, counter_o == limit_i
- wrap_o  output  1  registered one-cycle pulse; high in the cycle the counter shows 0 after a wrap
- wrap_count_o  output  wrap_width_p  number of wrap events since reset or clear, modulo 2^wrap_width_p

## Operation
- **Reset.** While reset_n_i = 0, asynchronously: counter_o = 0, wrap_o = 0, wrap_count_o = 0.
- **Priority each edge.** clear_i, then en_i, then hold.
- **clear_i = 1.** counter_o <= 0, wrap_count_o <= 0, wrap_o <= 0, regardless of en_i and sat_i.
- **en_i = 0, clear_i = 0.** Counter and wrap count hold; wrap_o <= 0.
- **en_i = 1, counter_o < limit_i.** counter_o <= counter_o + 1; wrap_o <= 0.
- **en_i = 1, counter_o >= limit_i, sat_i = 0 (wrap event).**
  - counter_o <= 0.
  - wrap_o <= 1.
  - wrap_count_o <= wrap_count_o + 1, dropping any carry out of wrap_width_p.
- **en_i = 1, counter_o >= limit_i, sat_i = 1.**
  - counter_o <= limit_i. This clamps down if the limit was lowered.
  - wrap_o <= 0; wrap count holds.
- **Comparisons.** Unsigned, full width_p. counter_o never increments past limit_i, so the +1 never overflows width_p.
- **limit_i = 0.**
  - Wrap mode: counter stays 0; every enabled cycle is a wrap event (wrap_o held high).
  - Saturate mode: counter stays 0, no events.
- **Limit lowered below counter_o.** The next enabled cycle wraps (sat_i = 0) or clamps (sat_i = 1). The counter never runs toward 2^width_p.
- **Limit raised.** Counting continues from the current value with no discontinuity.
- **sat_i changed mid-count.** Takes effect on the next enabled edge. A counter sitting at the limit in saturate mode wraps on the first enabled cycle after sat_i drops.
- **Limit = 2^width_p − 1, wrap mode.** Period is 2^width_p enabled cycles.

## Timing
- Latency: 1 cycle from en_i/clear_i/limit_i to counter_o and wrap_o; wrap_count_o updates on the same edge as counter_o.
- at_limit_o is combinational from counter_o and limit_i in the same cycle; no registered path.
- wrap_o is never high for a cycle in which counter_o != 0.
- Reset deassertion is synchronised externally. The first edge after reset_n_i rises behaves as a normal cycle.
- Reset asserted mid-count clears all state immediately, without waiting for a clock edge.

## Test plan
- **Basic wrap.** width_p = 8, limit_i = 3, sat_i = 0, en_i = 1 for 10 cycles after reset.
  - counter_o: 0,1,2,3,0,1,2,3,0,1,2.
  - wrap_o high exactly at the two 0s after a 3.
  - wrap_count_o ends at 2.
- **Enable gating and saturate.** limit_i = 5, sat_i = 1, en_i toggled 1,0,1,1,1,1,1,1.
  - Counter advances only on en_i = 1 cycles, then sticks at 5.
  - at_limit_o = 1 from then on; wrap_o never asserts.
- **Lowered limit.** Count to 20 with limit_i = 50, then set limit_i = 10 with en_i = 1.
  - sat_i = 0: next counter_o = 0, wrap_o = 1.
  - sat_i = 1: next counter_o = 10.
- **Clear and async reset priority.**
  - clear_i = 1 with en_i = 1 at count 7, wrap_count 3: next cycle counter_o = 0, wrap_count_o = 0, wrap_o = 0.
  - Then drop reset_n_i mid-cycle: outputs zero before the next edge.
- **Wrap-count rollover and limit 0.** wrap_width_p = 2, limit_i = 0, sat_i = 0, en_i = 1 for 6 cycles.
  - counter_o stays 0; wrap_o stays high.
  - wrap_count_o: 1,2,3,0,1,2.
- **Full range.** width_p = 4, limit_i = 15, sat_i = 0, en_i = 1.
  - Counter 0..15, then 0 (period 16); one wrap pulse per period.
